sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter OWNER_DEPTH, default 2, meaning the maximum number of outstanding accepted requests; legal values are 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports inst_req and data_req, input, 1 bit each: master request valid.
REQ-005 SHALL have ports inst_wr and data_wr, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports inst_size and data_size, input, 2 bits each: 0 = byte, 1 = half, 2 = word.
REQ-007 SHALL have ports inst_wstrb and data_wstrb, input, 4 bits each: byte-lane write strobe.
REQ-008 SHALL have ports inst_addr/inst_wdata and data_addr/data_wdata, input, 32 bits each: master address and write data.
REQ-009 SHALL have ports inst_addr_ok and data_addr_ok, output, 1 bit each: request accepted.
REQ-010 SHALL have ports inst_data_ok and data_data_ok, output, 1 bit each: response valid.
REQ-011 SHALL have ports inst_rdata and data_rdata, output, 32 bits each: read data.
REQ-012 SHALL have ports mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata, output, widths 1/1/2/4/32/32: shared slave request.
REQ-013 SHALL have ports mem_addr_ok and mem_data_ok, input, 1 bit each, and port mem_rdata, input, 32 bits: shared slave response.

Function
REQ-014 SHALL forward exactly one master's request fields to mem_* each cycle: the granted master; fields are 0 when no master is granted.
REQ-015 SHALL grant only when owner-FIFO count < OWNER_DEPTH; when count == OWNER_DEPTH, mem_req=0 and both *_addr_ok=0.
REQ-016 SHALL give data priority: when unlocked and both masters request, data is granted.
REQ-017 SHALL lock the grant: once mem_req=1 and mem_addr_ok=0, the same master stays granted until a cycle with mem_addr_ok=1, even if the other master has priority.
REQ-018 SHALL set lock_valid/lock_owner at the posedge ending a cycle with mem_req & ~mem_addr_ok, and clear lock_valid at the posedge ending a cycle with mem_req & mem_addr_ok.
REQ-019 SHALL route mem_addr_ok combinationally to the granted master only; the other master's addr_ok is 0.
REQ-020 SHALL push the owner ID (0 = inst, 1 = data) into an in-order FIFO on every mem_req & mem_addr_ok handshake.
REQ-021 SHALL pop the FIFO on mem_data_ok when count > 0, and route mem_data_ok combinationally to the head owner's *_data_ok.
REQ-022 SHALL broadcast mem_rdata unchanged to both inst_rdata and data_rdata; only *_data_ok qualifies it.
REQ-023 SHALL, on a simultaneous push and pop, leave count unchanged; data_ok goes to the old head and the new ID is written at the tail.
REQ-024 SHALL ignore mem_data_ok when count == 0: no *_data_ok is asserted and no state changes.
REQ-025 SHALL wrap FIFO pointers modulo OWNER_DEPTH; count ranges 0..OWNER_DEPTH.
REQ-026 SHALL treat the slave as returning data_ok strictly in request-acceptance order; routing relies only on the FIFO head.

Reset
REQ-027 SHALL, while reset=1, force mem_req=0, all *_addr_ok=0 and all *_data_ok=0.
REQ-028 SHALL, at the posedge with reset=1, clear count, both pointers and lock_valid, mid-transaction included; outstanding responses are discarded.
REQ-029 SHALL accept a new grant in the first cycle after reset deasserts.

Verification
REQ-030 SHALL be covered by this scenario: inst_req and data_req both 1, mem_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr, FIFO head=1.
REQ-031 SHALL be covered by this scenario: inst_req=1 with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> mem_addr stays inst_addr until addr_ok; data is granted the next cycle.
REQ-032 SHALL be covered by this scenario: accept inst then data (OWNER_DEPTH=2), third request pending -> mem_req=0; then mem_data_ok twice -> inst_data_ok then data_data_ok, one per pulse.
REQ-033 SHALL be covered by this scenario: count=1 (inst), same-cycle data accept plus mem_data_ok -> inst_data_ok=1, count remains 1, head=data.
REQ-034 SHALL be covered by this scenario: spurious mem_data_ok with count=0 -> both *_data_ok=0, count=0.
REQ-035 SHALL be covered by this scenario: reset asserted with count=2 and lock set -> next cycle count=0, mem_req follows the new request, and a late mem_data_ok is ignored.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: merges an instruction master and a data master onto one SRAM-style
// slave port. Data has priority, a stalled grant is locked until the slave accepts it,
// and an in-order owner FIFO routes each returning response to the master that issued it.
// OWNER_DEPTH bounds the outstanding accepted requests (legal values: 2 or 4).
module sram_arbiter #(
  parameter int OWNER_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared slave
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PTR_W = $clog2(OWNER_DEPTH);
  localparam int CNT_W = $clog2(OWNER_DEPTH + 1);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  owner_e           owner_q [OWNER_DEPTH];
  owner_e           owner_d [OWNER_DEPTH];
  logic             lock_valid_q, lock_valid_d;
  owner_e           lock_owner_q, lock_owner_d;

  logic   grant_valid;
  owner_e grant_owner;
  logic   push;
  logic   pop;
  owner_e head_owner;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(OWNER_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Pick the granted master: nothing while in reset or with the owner FIFO full,
  // the locked master while a stalled request is pending, otherwise data over inst.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    if (!reset && (count_q < CNT_W'(OWNER_DEPTH))) begin
      if (lock_valid_q) begin
        grant_owner = lock_owner_q;
        grant_valid = (lock_owner_q == OWNER_DATA) ? data_req : inst_req;
      end else if (data_req) begin
        grant_owner = OWNER_DATA;
        grant_valid = 1'b1;
      end else if (inst_req) begin
        grant_owner = OWNER_INST;
        grant_valid = 1'b1;
      end
    end
  end

  // Forward the granted master's request fields; all zero when nobody is granted.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_valid) begin
      mem_req = 1'b1;
      if (grant_owner == OWNER_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  // Handshake routing: addr_ok to the granted master, data_ok to the FIFO head owner.
  // A data_ok with nothing outstanding (or during reset) is dropped.
  assign push         = grant_valid && mem_addr_ok;
  assign pop          = !reset && mem_data_ok && (count_q != '0);
  assign head_owner   = owner_q[rd_ptr_q];
  assign inst_addr_ok = push && (grant_owner == OWNER_INST);
  assign data_addr_ok = push && (grant_owner == OWNER_DATA);
  assign inst_data_ok = pop && (head_owner == OWNER_INST);
  assign data_data_ok = pop && (head_owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Next state for the owner FIFO and the grant lock.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    owner_d      = owner_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;

    if (push) begin
      owner_d[wr_ptr_q] = grant_owner;
      wr_ptr_d          = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (grant_valid && !mem_addr_ok) begin
      lock_valid_d = 1'b1;
      lock_owner_d = grant_owner;
    end else if (push) begin
      lock_valid_d = 1'b0;
    end
  end

  // Control state register with synchronous reset; outstanding responses are forgotten.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWNER_INST;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  // Owner storage update.
  // NOTE: the storage array has no reset; count and pointers already make stale entries unreachable.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter (OWNER_DEPTH = 2). The stimulus thread drives
// directed cycles and queues the expected address handshakes and responses; a monitor
// on the falling edge pops and compares whenever the DUT raises an addr_ok or data_ok.
module tb_sram_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_arbiter #(.OWNER_DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } addr_exp_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } resp_exp_t;

  addr_exp_t addr_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok,
                       input logic [31:0] rd);
    inst_req    = ir;
    data_req    = dr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic expect_inst_accept();
    addr_q.push_back('{owner: 1'b0, wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                       addr: inst_addr, wdata: inst_wdata});
  endtask

  task automatic expect_data_accept();
    addr_q.push_back('{owner: 1'b1, wr: data_wr, size: data_size, wstrb: data_wstrb,
                       addr: data_addr, wdata: data_wdata});
  endtask

  task automatic expect_resp(input logic owner, input logic [31:0] rd);
    resp_q.push_back('{owner: owner, rdata: rd});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"},      32'(mem_req),      32'd0);
    check({tag, "_inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
    check({tag, "_data_addr_ok"}, 32'(data_addr_ok), 32'd0);
    check({tag, "_inst_data_ok"}, 32'(inst_data_ok), 32'd0);
    check({tag, "_data_data_ok"}, 32'(data_data_ok), 32'd0);
  endtask

  // Monitor: every addr_ok / data_ok pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (inst_addr_ok || data_addr_ok) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_addr_ok: got inst=%0b data=%0b, expected none",
                 inst_addr_ok, data_addr_ok);
      end else begin
        addr_exp_t e;
        e = addr_q.pop_front();
        check("addr_ok_route", 32'({inst_addr_ok, data_addr_ok}), e.owner ? 32'd1 : 32'd2);
        check("mem_addr",  mem_addr,           e.addr);
        check("mem_wdata", mem_wdata,          e.wdata);
        check("mem_ctrl",  32'({mem_wr, mem_size, mem_wstrb}), 32'({e.wr, e.size, e.wstrb}));
      end
    end
    if (inst_data_ok || data_data_ok) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: got inst=%0b data=%0b, expected none",
                 inst_data_ok, data_data_ok);
      end else begin
        resp_exp_t r;
        r = resp_q.pop_front();
        check("data_ok_route", 32'({inst_data_ok, data_data_ok}), r.owner ? 32'd1 : 32'd2);
        check("inst_rdata", inst_rdata, r.rdata);
        check("data_rdata", data_rdata, r.rdata);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    inst_wr    = 1'b0;          inst_size  = 2'd2; inst_wstrb = 4'b0000;
    inst_addr  = 32'h1000_0040; inst_wdata = 32'h0000_0000;
    data_wr    = 1'b1;          data_size  = 2'd0; data_wstrb = 4'b0010;
    data_addr  = 32'hD000_0011; data_wdata = 32'hCAFE_F00D;

    // Reset: requests and slave strobes active, everything must stay quiet.
    reset = 1'b1;
    drive(1, 1, 1, 1, 32'h5555_AAAA);
    @(negedge clk);
    check_quiet("rst");
    check("rst_inst_rdata", inst_rdata, 32'h5555_AAAA);
    check("rst_data_rdata", data_rdata, 32'h5555_AAAA);
    next_cycle();
    reset = 1'b0;

    // Both request, slave ready: data wins, then its response returns.
    drive(1, 1, 1, 0, 0);
    expect_data_accept();
    @(negedge clk);
    check("prio_mem_addr", mem_addr, 32'hD000_0011);
    next_cycle();
    drive(0, 0, 0, 1, 32'hAAAA_0001);
    expect_resp(1, 32'hAAAA_0001);
    next_cycle();

    // Lock: inst stalls three cycles, data arrives in the second, inst keeps the grant.
    inst_addr = 32'h1000_0100;
    data_addr = 32'hD000_0200; data_size = 2'd1; data_wstrb = 4'b1100; data_wdata = 32'h1234_5678;
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    check("lock_c1_mem_req",  32'(mem_req), 32'd1);
    check("lock_c1_mem_addr", mem_addr, 32'h1000_0100);
    next_cycle();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    check("lock_c2_mem_addr", mem_addr, 32'h1000_0100);
    next_cycle();
    @(negedge clk);
    check("lock_c3_mem_addr", mem_addr, 32'h1000_0100);
    next_cycle();
    drive(1, 1, 1, 0, 0);
    expect_inst_accept();
    next_cycle();
    drive(0, 1, 1, 0, 0);
    expect_data_accept();
    next_cycle();

    // FIFO full (inst, data): a third request is held off, then responses drain in order.
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check("full_mem_req",   32'(mem_req), 32'd0);
    check("full_mem_addr",  mem_addr,  32'd0);
    check("full_mem_wdata", mem_wdata, 32'd0);
    next_cycle();
    drive(1, 0, 1, 1, 32'hBEEF_0001);
    expect_resp(0, 32'hBEEF_0001);
    @(negedge clk);
    check("full_pop_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1, 32'hBEEF_0002);
    expect_resp(1, 32'hBEEF_0002);
    next_cycle();

    // Same-cycle push and pop with one inst outstanding; head becomes data, count stays 1.
    inst_addr = 32'h1000_0300;
    drive(1, 0, 1, 0, 0);
    expect_inst_accept();
    next_cycle();
    data_addr = 32'hD000_0400; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'b0000; data_wdata = 0;
    drive(0, 1, 1, 1, 32'h0C0C_0003);
    expect_data_accept();
    expect_resp(0, 32'h0C0C_0003);
    next_cycle();
    inst_addr = 32'h1000_0500;
    drive(1, 0, 1, 0, 0);
    expect_inst_accept();
    next_cycle();
    drive(0, 1, 1, 0, 0);
    @(negedge clk);
    check("pp_full_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1, 32'h0C0C_0004);
    expect_resp(1, 32'h0C0C_0004);
    next_cycle();
    drive(0, 0, 0, 1, 32'h0C0C_0005);
    expect_resp(0, 32'h0C0C_0005);
    next_cycle();

    // Spurious data_ok with nothing outstanding, then two accepts must still fill the FIFO.
    drive(0, 0, 0, 1, 32'hDEAD_0006);
    @(negedge clk);
    check("spur_inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("spur_data_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    drive(1, 0, 1, 0, 0);
    expect_inst_accept();
    next_cycle();
    drive(0, 1, 1, 0, 0);
    expect_data_accept();
    next_cycle();
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    check("spur_full_mem_req", 32'(mem_req), 32'd0);
    next_cycle();

    // Reset with the FIFO full; outstanding responses are discarded.
    reset = 1'b1;
    resp_q.delete();
    drive(1, 1, 1, 1, 32'h7777_0007);
    @(negedge clk);
    check_quiet("rst_full");
    next_cycle();
    reset = 1'b0;
    inst_addr = 32'h1000_0600;
    drive(1, 0, 1, 0, 0);
    expect_inst_accept();
    @(negedge clk);
    check("post_rst_grant", 32'(mem_req), 32'd1);
    next_cycle();

    // Lock onto data with one outstanding, then reset mid-transaction.
    data_addr = 32'hD000_0700;
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_lock_addr", mem_addr, 32'hD000_0700);
    next_cycle();
    drive(1, 1, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_locked_addr", mem_addr, 32'hD000_0700);
    next_cycle();
    reset = 1'b1;
    resp_q.delete();
    drive(1, 0, 1, 1, 32'h7777_0008);
    @(negedge clk);
    check_quiet("rst_lock");
    next_cycle();
    reset = 1'b0;

    // After reset: lock gone, inst request is forwarded, late data_ok ignored.
    inst_addr = 32'h1000_0800;
    drive(1, 0, 0, 1, 32'h7777_0009);
    @(negedge clk);
    check("rst_new_mem_req",  32'(mem_req), 32'd1);
    check("rst_new_mem_addr", mem_addr, 32'h1000_0800);
    check("rst_late_inst_data_ok", 32'(inst_data_ok), 32'd0);
    check("rst_late_data_data_ok", 32'(data_data_ok), 32'd0);
    next_cycle();
    drive(1, 0, 1, 0, 0);
    expect_inst_accept();
    next_cycle();
    drive(0, 1, 1, 0, 0);
    expect_data_accept();
    next_cycle();
    drive(1, 1, 1, 0, 0);
    @(negedge clk);
    check("rst_count_full_mem_req", 32'(mem_req), 32'd0);
    next_cycle();
    drive(0, 0, 0, 1, 32'h9999_000A);
    expect_resp(0, 32'h9999_000A);
    next_cycle();
    drive(0, 0, 0, 1, 32'h9999_000B);
    expect_resp(1, 32'h9999_000B);
    next_cycle();

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check("resp_q_drained", 32'(resp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
